// File: rtl/hilo_mul_ctrl.sv
// HI/LO register sequencer for the 16-bit pipeline: a radix-2 shift-add multiply
// engine for mul, register reads for mfhi/mflo, and a decode-stage stall interlock.
module hilo_mul_ctrl #(
    parameter int unsigned DATA_W   = 16,
    parameter logic [3:0]  OPC_MUL  = 4'd13,
    parameter logic [3:0]  OPC_MFHI = 4'd12,
    parameter logic [3:0]  OPC_MFLO = 4'd14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              stall,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned ACC_W = 2 * DATA_W;
    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   mcand_q, mcand_d;
    logic [ACC_W-1:0]   acc_sum;
    logic [DATA_W-1:0]  mplier_q, mplier_d;
    logic [DATA_W-1:0]  hi_q, hi_d;
    logic [DATA_W-1:0]  lo_q, lo_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               rd_valid_q, rd_valid_d;

    logic is_mul, is_mfhi, is_mflo, is_hilo, accept;

    assign is_mul  = (opcode == OPC_MUL);
    assign is_mfhi = (opcode == OPC_MFHI);
    assign is_mflo = (opcode == OPC_MFLO);
    assign is_hilo = is_mul | is_mfhi | is_mflo;

    // Non-HI/LO instructions are always accepted so they flow past the engine.
    assign issue_ready = (state_q == S_IDLE) | ~is_hilo;
    assign accept      = issue_valid & issue_ready;
    assign stall       = issue_valid & (state_q == S_RUN) & is_hilo;

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        mcand_d  = {{DATA_W{1'b0}}, rs_data};
                        mplier_d = rt_data;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_RUN;
                    end else if (is_mfhi) begin
                        rd_data_d  = hi_q;
                        rd_valid_d = 1'b1;
                    end else if (is_mflo) begin
                        rd_data_d  = lo_q;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Commit includes this edge's partial product.
                if (cnt_q == CNT_LAST) begin
                    hi_d    = acc_sum[ACC_W-1:DATA_W];
                    lo_d    = acc_sum[DATA_W-1:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign busy     = (state_q == S_RUN);
    assign done     = done_q;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Bench for hilo_mul_ctrl: directed scenarios plus randomized multiplies, checked
// against a product/timing model built from plain arithmetic.
module tb_hilo_mul_ctrl;

    localparam logic [3:0] OPC_MUL  = 4'd13;
    localparam logic [3:0] OPC_MFHI = 4'd12;
    localparam logic [3:0] OPC_MFLO = 4'd14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [3:0]  opcode = 4'd0;
    logic [15:0] rs_data = 16'd0;
    logic [15:0] rt_data = 16'd0;
    logic        stall;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [15:0] hi_out, lo_out;
    logic        busy, done;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] exp_hi = 16'd0;
    logic [15:0] exp_lo = 16'd0;
    logic [15:0] exp_rd = 16'd0;

    hilo_mul_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .opcode      (opcode),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .stall       (stall),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        issue_valid = 1'b0;
        opcode      = 4'd0;
        rs_data     = 16'($urandom);
        rt_data     = 16'($urandom);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"},     32'(busy),     32'd0);
        chk({tag, ".done"},     32'(done),     32'd0);
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, ".rd_data"},  32'(rd_data),  32'd0);
        chk({tag, ".hi"},       32'(hi_out),   32'd0);
        chk({tag, ".lo"},       32'(lo_out),   32'd0);
        chk({tag, ".stall"},    32'(stall),    32'd0);
    endtask

    // mode: 0 quiet, 1 random traffic, 2 hold mflo, 3 hold opcode 0.
    // abort_at > 0 asserts rst in that RUN cycle.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                           input int mode, input int abort_at);
        logic [31:0] prod;
        logic [3:0]  opc;
        logic        vld;
        bit          hl;
        prod = 32'(a) * 32'(b);
        issue_valid = 1'b1;
        opcode      = OPC_MUL;
        rs_data     = a;
        rt_data     = b;
        #1;
        chk("mul.accept_ready", 32'(issue_ready), 32'd1);
        chk("mul.accept_stall", 32'(stall), 32'd0);
        tick();
        for (int c = 1; c <= 16; c++) begin
            case (mode)
                1: begin
                    opc = 4'($urandom_range(0, 15));
                    vld = 1'($urandom_range(0, 1));
                end
                2: begin
                    opc = OPC_MFLO;
                    vld = 1'b1;
                end
                3: begin
                    opc = 4'd0;
                    vld = 1'b1;
                end
                default: begin
                    opc = 4'd0;
                    vld = 1'b0;
                end
            endcase
            issue_valid = vld;
            opcode      = opc;
            rs_data     = 16'($urandom);
            rt_data     = 16'($urandom);
            #1;
            hl = (opc == OPC_MUL) || (opc == OPC_MFHI) || (opc == OPC_MFLO);
            chk("run.busy",     32'(busy),        32'd1);
            chk("run.done",     32'(done),        32'd0);
            chk("run.rd_valid", 32'(rd_valid),    32'd0);
            chk("run.rd_data",  32'(rd_data),     32'(exp_rd));
            chk("run.hi_old",   32'(hi_out),      32'(exp_hi));
            chk("run.lo_old",   32'(lo_out),      32'(exp_lo));
            chk("run.ready",    32'(issue_ready), 32'(!hl));
            chk("run.stall",    32'(stall),       32'(vld && hl));
            if (c == abort_at) begin
                issue_valid = 1'b0;
                rst = 1'b1;
                #1;
                exp_hi = 16'd0;
                exp_lo = 16'd0;
                exp_rd = 16'd0;
                chk_zero("abort");
                #2;
                rst = 1'b0;
                return;
            end
            tick();
        end
        issue_valid = 1'b0;
        exp_hi = prod[31:16];
        exp_lo = prod[15:0];
        chk("end.done",     32'(done),     32'd1);
        chk("end.busy",     32'(busy),     32'd0);
        chk("end.rd_valid", 32'(rd_valid), 32'd0);
        chk("end.hi",       32'(hi_out),   32'(exp_hi));
        chk("end.lo",       32'(lo_out),   32'(exp_lo));
    endtask

    task automatic do_mf(input bit sel_hi);
        issue_valid = 1'b1;
        opcode      = sel_hi ? OPC_MFHI : OPC_MFLO;
        #1;
        chk("mf.ready", 32'(issue_ready), 32'd1);
        chk("mf.stall", 32'(stall), 32'd0);
        tick();
        exp_rd = sel_hi ? exp_hi : exp_lo;
        chk("mf.rd_valid", 32'(rd_valid), 32'd1);
        chk("mf.rd_data",  32'(rd_data),  32'(exp_rd));
        chk("mf.done",     32'(done),     32'd0);
        drive_idle();
        tick();
        chk("mf.rd_valid_pulse", 32'(rd_valid), 32'd0);
        chk("mf.rd_data_hold",   32'(rd_data),  32'(exp_rd));
    endtask

    initial begin
        logic [15:0] a, b;
        drive_idle();
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        run_mul(16'd3, 16'd5, 0, 0);
        chk("t1.lo_f", 32'(lo_out), 32'h000F);
        drive_idle();
        tick();
        chk("t1.done_pulse", 32'(done), 32'd0);

        run_mul(16'hFFFF, 16'hFFFF, 0, 0);
        drive_idle();
        tick();
        do_mf(1'b1);
        chk("t2.rd_hi", 32'(rd_data), 32'hFFFE);
        do_mf(1'b0);
        chk("t2.rd_lo", 32'(rd_data), 32'h0001);

        run_mul(16'h1234, 16'h0100, 2, 0);
        do_mf(1'b0);
        chk("t3.rd_lo", 32'(rd_data), 32'h3400);

        run_mul(16'd7, 16'd9, 0, 8);
        tick();
        chk_zero("t4.after_release");
        run_mul(16'd2, 16'd2, 0, 0);
        chk("t4.lo4", 32'(lo_out), 32'd4);
        drive_idle();
        tick();

        run_mul(16'd2, 16'd3, 0, 0);
        run_mul(16'h0100, 16'h0100, 0, 0);
        chk("t5.hi", 32'(hi_out), 32'h0001);
        chk("t5.lo", 32'(lo_out), 32'h0000);
        drive_idle();
        tick();

        run_mul(16'h00AB, 16'h0CD0, 3, 0);
        drive_idle();
        tick();

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: a = 16'hFFFF;
                1: a = 16'd0;
                default: a = 16'($urandom);
            endcase
            b = (i % 5 == 0) ? 16'hFFFF : 16'($urandom);
            run_mul(a, b, 1, 0);
            drive_idle();
            case ($urandom_range(0, 3))
                0: do_mf(1'b1);
                1: do_mf(1'b0);
                2: tick();
                default: ;
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d checks, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hilo_mul_ctrl.md
Name: hilo_mul_ctrl

Overview:
- Multi-cycle sequencer that owns the HI/LO register pair and executes mul (opcode 13), mfhi (12) and mflo (14) for the 16-bit pipeline.
- Replaces the single-cycle combinational multiply with a radix-2 shift-add engine and provides an issue handshake.
- Raises a stall interlock toward the decode stage while a multiply is in flight.
- Sits beside the ALU in the execute stage; every other opcode passes through untouched.

Parameters:
- DATA_W, 16, operand width; HI and LO are each DATA_W bits.
- OPC_MUL, 13, opcode for mul [HI,LO] = Rs * Rt.
- OPC_MFHI, 12, opcode for mfhi Rd = HI.
- OPC_MFLO, 14, opcode for mflo Rd = LO.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  execute stage presents an instruction.
- issue_ready  out  1  block can accept the presented instruction this cycle.
- opcode  in  4  instruction opcode.
- rs_data  in  DATA_W  multiplicand.
- rt_data  in  DATA_W  multiplier.
- stall  out  1  freeze the upstream pipeline.
- rd_data  out  DATA_W  mfhi/mflo result.
- rd_valid  out  1  rd_data valid, 1-cycle pulse.
- hi_out  out  DATA_W  current HI register.
- lo_out  out  DATA_W  current LO register.
- busy  out  1  multiply in progress.
- done  out  1  multiply completed, 1-cycle pulse.

Behaviour:
- Reset:
  - Asynchronous, active-high; acts immediately, independent of clk.
  - State = IDLE.
  - HI, LO, rd_data and the internal accumulator/counter = 0.
  - busy, done, rd_valid and stall = 0.
  - Reset during RUN aborts the multiply; no partial result reaches HI/LO.
- Accept rule:
  - Accept occurs on a rising edge where issue_valid=1 and issue_ready=1.
  - issue_ready = 1 in IDLE.
  - issue_ready = 0 in RUN when opcode is mul, mfhi or mflo.
  - issue_ready = 1 in RUN for any other opcode.
- Stall:
  - Combinational: stall = issue_valid & (state==RUN) & (opcode in {MUL, MFHI, MFLO}).
  - Non-HI/LO opcodes never stall.
- FSM has 2 states:
  - IDLE -> RUN on accept of MUL.
  - RUN -> IDLE after the 16th RUN cycle.
- Mul datapath:
  - On accept: load multiplicand (zero-extended to 2*DATA_W), multiplier and a 2*DATA_W accumulator = 0; set the 5-bit counter to 0.
  - Each RUN edge:
    - If multiplier LSB = 1, add the multiplicand to the accumulator.
    - Shift the multiplicand left by 1 and the multiplier right by 1.
    - Increment the counter.
  - On the edge where counter == DATA_W-1:
    - HI <= acc[31:16] and LO <= acc[15:0], including that edge's final add.
    - State <= IDLE.
    - done <= 1 for exactly one cycle.
  - Arithmetic is unsigned 16x16 -> 32 with no overflow.
  - Operands are captured at accept; later rs/rt changes are ignored.
- Latency and busy:
  - Accept at edge E0; HI/LO update at edge E16.
  - busy is high from after E0 until E16: exactly 16 cycles.
  - done is high in the cycle after E16.
- mfhi/mflo:
  - Accepted only in IDLE.
  - Next edge: rd_data <= HI (or LO) and rd_valid <= 1 for one cycle.
  - rd_data holds its value until the next mfhi/mflo.
- Simultaneous events:
  - In the done cycle the state is IDLE, so a new MUL or an mfhi/mflo is accepted.
  - mfhi/mflo in the done cycle returns the new product.
  - A new MUL in the done cycle leaves HI/LO at the old product until its own E16.
- Other opcodes produce no state change, no rd_valid and no stall.
- hi_out/lo_out are registered and change only at the completion edge or on reset.

Test Plan:
- Reset, then MUL rs=3, rt=5 -> busy high 16 cycles; done pulse; hi_out=0x0000, lo_out=0x000F.
- MUL 0xFFFF*0xFFFF, then MFHI/MFLO -> hi_out=0xFFFE, lo_out=0x0001; rd_data=0xFFFE then 0x0001, each with a 1-cycle rd_valid.
- MUL 0x1234*0x0100, then MFLO held valid from the cycle after accept -> stall=1 and issue_ready=0 until the done cycle; accepted in the done cycle; rd_data=0x3400.
- MUL 7*9, then assert rst at RUN cycle 8 -> all outputs 0 immediately; after release hi/lo stay 0; next MUL 2*2 gives lo=4.
- Back-to-back: MUL 2*3, then MUL 0x0100*0x0100 issued in the done cycle -> lo=6 visible until the second E16, then hi=0x0001, lo=0x0000.
- Opcode 0 (add) with issue_valid during RUN -> issue_ready=1, stall=0, HI/LO/rd_valid unaffected.
